wave_gen_multi: RTL and testbench
=================================

# wave_gen_multi

Parametrised multi-channel waveform core: the next generation of the single-channel wave generator in the Tiny Tapeout top level. It runs NCH independent phase-accumulator channels, each with its own increment, waveform mode and square-wave duty. All channels share one sample-rate prescaler. Channels are configured through a simple register-write port, and the top level maps them to `uo_out` and `uio_out`.

## Interface
- `NCH`, 2: number of channels (≥1).
- `W`, 8: output sample width per channel.
- `PW`, 16: phase accumulator and increment width (PW ≥ W+1).
- `DIVW`, 8: prescaler width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable; low freezes prescaler and accumulators.
- `div`  in  DIVW  prescaler terminal value; tick period = div+1 cycles.
- `cfg_we`  in  1  config write strobe, one write per cycle.
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel.
- `cfg_sel`  in  2  field select: 0 = increment, 1 = mode (cfg_data[1:0]), 2 = duty (cfg_data[W-1:0]), 3 = phase load.
- `cfg_data`  in  PW  write data.
- `sample_tick`  out  1  one-cycle strobe: wave_out just updated.
- `wave_out`  out  NCH*W  channel c occupies bits [c*W +: W].

## Operation
- Per-channel state: phase[PW], inc[PW], mode[2], duty[W].
- Prescaler counter `cnt` (DIVW bits). When en=1:
  - if cnt ≥ div, assert internal tick and set cnt ← 0;
  - else cnt ← cnt+1.
  - Using ≥ makes a mid-count reduction of `div` tick immediately, with no wrap-around.
- On tick, for every channel:
  - wave_out[c] ← f(phase_c, mode_c, duty_c), using the current (pre-advance) phase;
  - phase_c ← phase_c + inc_c, mod 2^PW (silent wrap).
- Let t = phase[PW-1 -: W] and p = phase[PW-2 -: W]. Waveform f by mode:
  - 0 square: all-ones if t < duty, else 0. duty=0 gives constant 0.
  - 1 sawtooth: t.
  - 2 triangle: phase[PW-1] ? ~p : p.
  - 3 off: 0.
- Config write with cfg_ch ≥ NCH is ignored.
- Write vs tick in the same cycle:
  - inc, mode and duty writes register, but that tick uses the old values.
  - A phase load (sel 3) overrides accumulation: phase ← cfg_data, with no increment that cycle.
- en=0: cnt, phase and wave_out hold. Config writes still take effect.

## Timing
- Reset values: cnt=0, sample_tick=0, wave_out=0, phase=0, inc=0, mode=3 (off), duty=2^(W-1).
- Reset is synchronous; asserting it mid-operation clears everything on the next edge, and rst has priority over en and cfg_we.
- Latency:
  - wave_out and sample_tick are registered and change the cycle after the tick condition.
  - sample_tick is high exactly in the first cycle each new wave_out is visible.
- Sample rate: with div=0 and en=1, sample_tick is high every cycle. In general one tick every div+1 enabled cycles.
- Config latency: a write is visible to the first tick occurring strictly after the write cycle.

## Test plan
- **Reset/idle:** rst 2 cycles, then en=1, div=0 for 10 cycles.
  - wave_out=0 throughout (all mode off).
  - sample_tick high every cycle from the first enabled tick onward.
- **Sawtooth:** ch0 inc=0x0100, mode=1, div=0.
  - Successive wave_out[7:0] = 0x00, 0x01, 0x02, …, 0xFF, 0x00 (wraps after 256 ticks).
  - ch1 stays 0.
- **Square:** ch1 inc=0x1000, mode=0, duty=0x80.
  - wave_out[15:8] = 0xFF for 8 ticks, then 0x00 for 8 ticks; period 16.
  - duty=0x00 gives constant 0.
- **Triangle:** ch0 inc=0x0800, mode=2.
  - Output 0x00, 0x10, …, 0xF0, then 0xFF, 0xEF, …, 0x0F, then repeats.
- **Prescaler/enable:** div=3.
  - sample_tick period is 4 cycles.
  - Drop en for 5 cycles: no ticks, wave_out and phase hold, and the period resumes with cnt unchanged.
  - Changing div from 7 to 1 while cnt=5 ticks on the next cycle.
- **Collision/reset:** saw ch0 inc=0x0100; assert a sel-3 write of 0x4000 in the same cycle as a tick.
  - That tick outputs the old phase.
  - The next tick outputs 0x40, then 0x41.
  - Assert rst mid-stream: all outputs read 0 the following cycle.
  - cfg_ch=2 with NCH=2 changes nothing.

Source files
------------

// File: rtl/wave_gen_multi.sv
// wave_gen_multi: NCH independent phase-accumulator waveform channels sharing one
// sample-rate prescaler; channel c drives wave_out[c*W +: W].
module wave_gen_multi #(
  parameter int NCH  = 2,
  parameter int W    = 8,
  parameter int PW   = 16,
  parameter int DIVW = 8,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIVW-1:0]  div,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [PW-1:0]    cfg_data,
  output logic             sample_tick,
  output logic [NCH*W-1:0] wave_out
);

  localparam logic [1:0] SEL_INC     = 2'd0;
  localparam logic [1:0] SEL_MODE    = 2'd1;
  localparam logic [1:0] SEL_DUTY    = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            sample_tick_q, sample_tick_d;

  // Comparing with >= lets a mid-count reduction of div tick at once instead of wrapping.
  always_comb begin
    tick          = en && (cnt_q >= div);
    cnt_d         = cnt_q;
    sample_tick_d = tick;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIVW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  assign sample_tick = sample_tick_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PW-1:0] phase_q, phase_d;
      logic [PW-1:0] inc_q, inc_d;
      logic [1:0]    mode_q, mode_d;
      logic [W-1:0]  duty_q, duty_d;
      logic [W-1:0]  wave_q, wave_d;
      logic [W-1:0]  shape, t, p;
      logic          hit;

      // Out-of-range channel numbers never match any gi, so such writes are dropped.
      assign hit = cfg_we && (cfg_ch == CW'(gi));
      assign t   = phase_q[PW-1 -: W];
      assign p   = phase_q[PW-2 -: W];

      always_comb begin
        shape = '0;
        case (mode_q)
          MODE_SQUARE: shape = (t < duty_q) ? '1 : '0;
          MODE_SAW:    shape = t;
          MODE_TRI:    shape = phase_q[PW-1] ? ~p : p;
          default:     shape = '0;
        endcase
      end

      // The tick samples the registered (old) config; a phase load replaces the advance.
      always_comb begin
        inc_d   = inc_q;
        mode_d  = mode_q;
        duty_d  = duty_q;
        phase_d = phase_q;
        wave_d  = wave_q;
        if (tick) begin
          wave_d  = shape;
          phase_d = phase_q + inc_q;
        end
        if (hit) begin
          case (cfg_sel)
            SEL_INC:  inc_d   = cfg_data;
            SEL_MODE: mode_d  = cfg_data[1:0];
            SEL_DUTY: duty_d  = cfg_data[W-1:0];
            default:  phase_d = cfg_data;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          phase_q <= '0;
          inc_q   <= '0;
          mode_q  <= MODE_OFF;
          duty_q  <= {1'b1, {(W-1){1'b0}}};
          wave_q  <= '0;
        end else begin
          phase_q <= phase_d;
          inc_q   <= inc_d;
          mode_q  <= mode_d;
          duty_q  <= duty_d;
          wave_q  <= wave_d;
        end
      end

      assign wave_out[gi*W +: W] = wave_q;
    end
  endgenerate

endmodule

// File: tb/tb_wave_gen_multi.sv
// Self-checking bench for wave_gen_multi: directed loops for the waveform shapes,
// a vector table for prescaler/enable/collision timing, and an NCH=3 decode check.
module tb_wave_gen_multi;
  logic        clk = 1'b0;
  logic        rst, en, cfg_we;
  logic [7:0]  div;
  logic [0:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        sample_tick;
  logic [15:0] wave_out;

  logic        c3_we;
  logic [1:0]  c3_ch, c3_sel;
  logic [15:0] c3_data;
  logic        c3_tick;
  logic [23:0] c3_wave;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wave_gen_multi #(.NCH(2), .W(8), .PW(16), .DIVW(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .div(div),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .sample_tick(sample_tick), .wave_out(wave_out)
  );

  wave_gen_multi #(.NCH(3), .W(8), .PW(16), .DIVW(8)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .div(div),
    .cfg_we(c3_we), .cfg_ch(c3_ch), .cfg_sel(c3_sel), .cfg_data(c3_data),
    .sample_tick(c3_tick), .wave_out(c3_wave)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [7:0]  div;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        exp_tick;
    logic [15:0] exp_wave;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(string name, logic e, logic [7:0] d, logic w,
                               logic [1:0] s, logic [15:0] data, logic et, logic [15:0] ew);
    vec_t v;
    v.name = name; v.en = e; v.div = d; v.we = w; v.sel = s; v.data = data;
    v.exp_tick = et; v.exp_wave = ew;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [0:0] ch, logic [1:0] sel, logic [15:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
    $display("cfg write ch%0d sel%0d data=%04h", ch, sel, data);
  endtask

  task automatic wr3(logic [1:0] ch, logic [1:0] sel, logic [15:0] data);
    c3_we = 1'b1; c3_ch = ch; c3_sel = sel; c3_data = data;
    step();
    c3_we = 1'b0;
    $display("nch3 cfg write ch%0d sel%0d data=%04h", ch, sel, data);
  endtask

  function automatic logic [7:0] tri_model(int k);
    int m;
    m = k % 32;
    return (m < 16) ? 8'(m * 16) : 8'(255 - (m - 16) * 16);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    c3_we = 1'b0; c3_ch = '0; c3_sel = '0; c3_data = '0;

    // Reset / idle
    step(); step();
    chk("reset_wave", {16'h0, wave_out}, 32'h0);
    chk("reset_tick", {31'h0, sample_tick}, 32'h0);
    chk("reset_wave_nch3", {8'h0, c3_wave}, 32'h0);
    rst = 1'b0; en = 1'b1; div = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_tick", {31'h0, sample_tick}, 32'h1);
      chk("idle_wave", {16'h0, wave_out}, 32'h0);
    end
    $display("idle: 10 enabled cycles");

    // Sawtooth on ch0
    en = 1'b0;
    wr(1'b0, 2'd0, 16'h0100);
    wr(1'b0, 2'd1, 16'h0001);
    en = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      logic [7:0] kb;
      kb = k[7:0];
      step();
      chk("saw_tick", {31'h0, sample_tick}, 32'h1);
      chk("saw_wave", {16'h0, wave_out}, {16'h0, 8'h00, kb});
    end
    $display("sawtooth: 257 ticks");

    // Square on ch1, duty 0x80 then duty 0
    en = 1'b0;
    wr(1'b0, 2'd1, 16'h0003);
    wr(1'b1, 2'd0, 16'h1000);
    wr(1'b1, 2'd1, 16'h0000);
    wr(1'b1, 2'd2, 16'h0080);
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [7:0] sq;
      sq = ((k % 16) < 8) ? 8'hFF : 8'h00;
      step();
      chk("square_wave", {16'h0, wave_out}, {16'h0, sq, 8'h00});
    end
    $display("square: 32 ticks duty=80");
    en = 1'b0;
    wr(1'b1, 2'd2, 16'h0000);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("square_duty0", {16'h0, wave_out}, 32'h0);
    end
    $display("square: 16 ticks duty=00");

    // Triangle on ch0
    en = 1'b0;
    wr(1'b1, 2'd1, 16'h0003);
    wr(1'b0, 2'd0, 16'h0800);
    wr(1'b0, 2'd1, 16'h0002);
    wr(1'b0, 2'd3, 16'h0000);
    en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      chk("triangle_wave", {16'h0, wave_out}, {16'h0, 8'h00, tri_model(k)});
    end
    $display("triangle: 64 ticks");

    // Prescaler / enable / collision table: ch0 sawtooth inc 0x0100 from phase 0
    en = 1'b0;
    wr(1'b0, 2'd0, 16'h0100);
    wr(1'b0, 2'd1, 16'h0001);
    wr(1'b0, 2'd3, 16'h0000);
    for (int i = 0; i < 3; i++) addv("pre_count", 1, 3, 0, 0, 0, 0, 16'h000F);
    addv("pre_tick", 1, 3, 0, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 3; i++) addv("pre_count", 1, 3, 0, 0, 0, 0, 16'h0000);
    addv("pre_tick", 1, 3, 0, 0, 0, 1, 16'h0001);
    for (int i = 0; i < 2; i++) addv("pre_count", 1, 3, 0, 0, 0, 0, 16'h0001);
    for (int i = 0; i < 5; i++) addv("en_low_hold", 0, 3, 0, 0, 0, 0, 16'h0001);
    addv("en_resume", 1, 3, 0, 0, 0, 0, 16'h0001);
    addv("en_resume_tick", 1, 3, 0, 0, 0, 1, 16'h0002);
    for (int i = 0; i < 5; i++) addv("div7_count", 1, 7, 0, 0, 0, 0, 16'h0002);
    addv("div_drop_tick", 1, 1, 0, 0, 0, 1, 16'h0003);
    addv("div1_count", 1, 1, 0, 0, 0, 0, 16'h0003);
    addv("div1_tick", 1, 1, 0, 0, 0, 1, 16'h0004);
    addv("load_while_off", 0, 0, 1, 3, 16'h0000, 0, 16'h0004);
    addv("coll_run", 1, 0, 0, 0, 0, 1, 16'h0000);
    addv("coll_run", 1, 0, 0, 0, 0, 1, 16'h0001);
    addv("coll_load", 1, 0, 1, 3, 16'h4000, 1, 16'h0002);
    addv("coll_after", 1, 0, 0, 0, 0, 1, 16'h0040);
    addv("coll_after", 1, 0, 0, 0, 0, 1, 16'h0041);
    addv("coll_inc", 1, 0, 1, 0, 16'h0200, 1, 16'h0042);
    addv("coll_inc_new", 1, 0, 0, 0, 0, 1, 16'h0043);
    addv("coll_inc_new", 1, 0, 0, 0, 0, 1, 16'h0045);
    addv("coll_mode", 1, 0, 1, 1, 16'h0003, 1, 16'h0047);
    addv("coll_mode_new", 1, 0, 0, 0, 0, 1, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; div = vecs[i].div;
      cfg_we = vecs[i].we; cfg_ch = 1'b0; cfg_sel = vecs[i].sel; cfg_data = vecs[i].data;
      step();
      $display("vec %0d %s en=%0d div=%0d we=%0d tick=%0d wave=%04h",
               i, vecs[i].name, vecs[i].en, vecs[i].div, vecs[i].we, sample_tick, wave_out);
      chk({vecs[i].name, "_tick"}, {31'h0, sample_tick}, {31'h0, vecs[i].exp_tick});
      chk({vecs[i].name, "_wave"}, {16'h0, wave_out}, {16'h0, vecs[i].exp_wave});
    end
    cfg_we = 1'b0;

    // Mid-stream reset, then reset duty (0x80) seen through square mode on ch1
    rst = 1'b1; en = 1'b1; div = 8'd0;
    step();
    chk("midrst_wave", {16'h0, wave_out}, 32'h0);
    chk("midrst_tick", {31'h0, sample_tick}, 32'h0);
    rst = 1'b0; en = 1'b0;
    wr(1'b1, 2'd1, 16'h0000);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_duty_tick", {31'h0, sample_tick}, 32'h1);
      chk("rst_duty_wave", {16'h0, wave_out}, 32'h0000FF00);
    end
    $display("post-reset: 3 ticks");

    // Out-of-range channel on NCH=3 instance; ch2 write is the positive control
    en = 1'b0;
    wr3(2'd3, 2'd0, 16'h0100);
    wr3(2'd3, 2'd1, 16'h0001);
    wr3(2'd3, 2'd2, 16'h0000);
    wr3(2'd2, 2'd0, 16'h0100);
    wr3(2'd2, 2'd1, 16'h0001);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] kb;
      kb = k[7:0];
      step();
      chk("nch3_ignore_ch3", {8'h0, c3_wave}, {8'h0, kb, 16'h0000});
    end
    $display("nch3: 4 ticks");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
